// File: rtl/seq_pattern_tx_if.sv
// Request/stream bundle for the serial pattern transmitter.
// The master side issues pattern requests and consumes the serial stream.
interface seq_pattern_tx_if #(
  parameter int PAT_W = 4,
  parameter int LEN_W = 3,
  parameter int CNT_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [PAT_W-1:0] pat_in;
  logic [LEN_W-1:0] pat_len;
  logic [CNT_W-1:0] rep_cnt;
  logic             abort;
  logic             out_bit;
  logic             out_valid;
  logic             busy;
  logic             done;

  modport master (
    output in_valid, pat_in, pat_len, rep_cnt, abort,
    input  in_ready, out_bit, out_valid, busy, done
  );

  modport slave (
    input  in_valid, pat_in, pat_len, rep_cnt, abort,
    output in_ready, out_bit, out_valid, busy, done
  );
endinterface

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts a latched pattern out MSB-first,
// repeated rep_cnt times with an optional idle gap between repetitions.
//
// state | meaning
// IDLE  | ready for a request
// SHIFT | driving one pattern bit per cycle
// GAP   | idle cycles between repetitions
// DONE  | one-cycle completion pulse
module seq_pattern_tx #(
  parameter int PAT_W   = 4,
  parameter int LEN_W   = 3,
  parameter int CNT_W   = 4,
  parameter int GAP_CYC = 0
) (
  input  logic         clk,
  input  logic         reset,
  seq_pattern_tx_if.slave bus
);
  localparam int GAP_W = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

  state_t           state, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] idx, idx_d;
  logic [CNT_W-1:0] rep_left, rep_d;
  logic [GAP_W-1:0] gap_ctr, gap_d;
  logic [LEN_W-1:0] eff_len;
  logic [PAT_W-1:0] pat_shifted;

  // Out-of-range lengths fall back to the full pattern width.
  always_comb begin
    eff_len = bus.pat_len;
    if (bus.pat_len == '0 || bus.pat_len > LEN_W'(PAT_W))
      eff_len = LEN_W'(PAT_W);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      pat_q    <= '0;
      len_q    <= '0;
      idx      <= '0;
      rep_left <= '0;
      gap_ctr  <= '0;
    end else begin
      state    <= state_d;
      pat_q    <= pat_d;
      len_q    <= len_d;
      idx      <= idx_d;
      rep_left <= rep_d;
      gap_ctr  <= gap_d;
    end
  end

  always_comb begin
    state_d = state;
    pat_d   = pat_q;
    len_d   = len_q;
    idx_d   = idx;
    rep_d   = rep_left;
    gap_d   = gap_ctr;
    if (bus.abort) begin
      state_d = IDLE;
      idx_d   = '0;
      rep_d   = '0;
      gap_d   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            pat_d   = bus.pat_in;
            len_d   = eff_len;
            idx_d   = eff_len - LEN_W'(1);
            rep_d   = bus.rep_cnt;
            state_d = (bus.rep_cnt == '0) ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          if (idx != '0) begin
            idx_d = idx - LEN_W'(1);
          end else if (rep_left > CNT_W'(1)) begin
            rep_d = rep_left - CNT_W'(1);
            idx_d = len_q - LEN_W'(1);
            if (GAP_CYC > 0) begin
              state_d = GAP;
              gap_d   = GAP_INIT;
            end
          end else begin
            rep_d   = '0;
            state_d = DONE;
          end
        end
        GAP: begin
          if (gap_ctr == '0) state_d = SHIFT;
          else               gap_d   = gap_ctr - GAP_W'(1);
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign pat_shifted   = pat_q >> idx;
  assign bus.out_valid = (state == SHIFT);
  assign bus.out_bit   = (state == SHIFT) & pat_shifted[0];
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
  assign bus.in_ready  = (state == IDLE);
endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: a back-to-back build and a GAP_CYC=2
// build share one clock; inputs are driven and outputs sampled on negedge.
module tb_seq_pattern_tx;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  seq_pattern_tx_if #(.PAT_W(4), .LEN_W(3), .CNT_W(4)) b0 ();
  seq_pattern_tx_if #(.PAT_W(4), .LEN_W(3), .CNT_W(4)) b2 ();

  seq_pattern_tx #(.PAT_W(4), .LEN_W(3), .CNT_W(4), .GAP_CYC(0)) u0 (
    .clk(clk), .reset(reset), .bus(b0.slave));
  seq_pattern_tx #(.PAT_W(4), .LEN_W(3), .CNT_W(4), .GAP_CYC(2)) u2 (
    .clk(clk), .reset(reset), .bus(b2.slave));

  int checks = 0;
  int errors = 0;

  logic [31:0] cap_bits;
  int          cap_n, cap_done, cap_gap, cap_bad, cap_seen;
  logic        v, b, d, rdy, bz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic iv, input logic [3:0] p,
                       input logic [2:0] l, input logic [3:0] r, input logic ab);
    if (sel == 0) begin
      b0.in_valid = iv; b0.pat_in = p; b0.pat_len = l; b0.rep_cnt = r; b0.abort = ab;
    end else begin
      b2.in_valid = iv; b2.pat_in = p; b2.pat_len = l; b2.rep_cnt = r; b2.abort = ab;
    end
  endtask

  task automatic samp(input int sel);
    if (sel == 0) begin
      v = b0.out_valid; b = b0.out_bit; d = b0.done; rdy = b0.in_ready; bz = b0.busy;
    end else begin
      v = b2.out_valid; b = b2.out_bit; d = b2.done; rdy = b2.in_ready; bz = b2.busy;
    end
  endtask

  // Present a request at the current negedge; returns at the negedge of cycle N+1.
  task automatic req(input int sel, input logic [3:0] p, input logic [2:0] l, input logic [3:0] r);
    samp(sel);
    chk("req_in_ready", rdy, 1'b1);
    drive(sel, 1'b1, p, l, r, 1'b0);
    @(negedge clk);
    drive(sel, 1'b0, 4'h0, 3'd0, 4'd0, 1'b0);
  endtask

  // Collect the stream until done (cycle index counted from accept), with an
  // overlapping 1011 detector standing in for the downstream sequence detector.
  task automatic capture(input int sel, input int max, input bit noise);
    logic [3:0] sr;
    sr = 4'h0;
    cap_bits = '0; cap_n = 0; cap_done = 0; cap_gap = 0; cap_bad = 0; cap_seen = 0;
    for (int c = 1; c <= max; c++) begin
      if (c > 1) @(negedge clk);
      samp(sel);
      if (v) begin
        cap_bits = {cap_bits[30:0], b};
        cap_n++;
        sr = {sr[2:0], b};
        if (cap_n >= 4 && sr == 4'b1011) cap_seen++;
      end else if (!d) begin
        cap_gap++;
        if (b !== 1'b0) cap_bad++;
      end
      if (d) begin
        cap_done = c;
        if (bz !== 1'b1 || rdy !== 1'b0) cap_bad++;
        drive(sel, 1'b0, 4'h0, 3'd0, 4'd0, 1'b0);
        break;
      end
      if (noise) drive(sel, 1'($urandom_range(0, 1)), 4'($urandom), 3'($urandom), 4'($urandom), 1'b0);
    end
  endtask

  task automatic after_done(input int sel, input string tag);
    @(negedge clk);
    samp(sel);
    chk({tag, "_done_one_cycle"}, {d, rdy, bz}, 3'b010);
  endtask

  initial begin
    bit seen_done;
    drive(0, 1'b0, 4'h0, 3'd0, 4'd0, 1'b0);
    drive(2, 1'b0, 4'h0, 3'd0, 4'd0, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    samp(0);
    chk("rst_outputs_g0", {b, v, bz, d, rdy}, 5'b00001);
    samp(2);
    chk("rst_outputs_g2", {b, v, bz, d, rdy}, 5'b00001);

    // single repetition of 1011
    req(0, 4'b1011, 3'd4, 4'd1);
    capture(0, 20, 1'b0);
    chk("t1_bits", cap_bits, 32'hB);
    chk("t1_nbits", cap_n, 4);
    chk("t1_done_at", cap_done, 5);
    after_done(0, "t1");

    // three repetitions back to back
    req(0, 4'b1011, 3'd4, 4'd3);
    capture(0, 30, 1'b0);
    chk("t2_bits", cap_bits, 32'hBBB);
    chk("t2_holes", cap_gap, 0);
    chk("t2_done_at", cap_done, 13);
    after_done(0, "t2");

    // gap build: 1011, two idle cycles, 1011
    req(2, 4'b1011, 3'd4, 4'd2);
    capture(2, 30, 1'b0);
    chk("t3_bits", cap_bits, 32'hBB);
    chk("t3_gap_cycles", cap_gap, 2);
    chk("t3_gap_bit_zero", cap_bad, 0);
    chk("t3_done_at", cap_done, 11);
    after_done(2, "t3");

    // length fallback for pat_len 0 and 7
    req(0, 4'b1101, 3'd0, 4'd1);
    capture(0, 20, 1'b0);
    chk("t4_len0_bits", {cap_bits[27:0], 4'(cap_n)}, {28'hD, 4'd4});
    after_done(0, "t4a");
    req(0, 4'b1101, 3'd7, 4'd1);
    capture(0, 20, 1'b0);
    chk("t4_len7_bits", {cap_bits[27:0], 4'(cap_n)}, {28'hD, 4'd4});
    after_done(0, "t4b");

    // short length uses only the low pat_len bits
    req(0, 4'b1110, 3'd2, 4'd2);
    capture(0, 20, 1'b0);
    chk("t4_len2_bits", cap_bits, 32'hA);
    chk("t4_len2_done_at", cap_done, 5);
    after_done(0, "t4c");

    // zero repetitions
    req(0, 4'b1011, 3'd4, 4'd0);
    capture(0, 10, 1'b0);
    chk("t4_rep0_nbits", cap_n, 0);
    chk("t4_rep0_done_at", cap_done, 1);
    after_done(0, "t4d");

    // abort on bit 2 of repetition 2 (cycle 6)
    req(0, 4'b1011, 3'd4, 4'd3);
    repeat (5) @(negedge clk);
    samp(0);
    chk("t5_pre_abort_bit", {v, b}, 2'b10);
    drive(0, 1'b0, 4'h0, 3'd0, 4'd0, 1'b1);
    @(negedge clk);
    drive(0, 1'b0, 4'h0, 3'd0, 4'd0, 1'b0);
    samp(0);
    chk("t5_after_abort", {v, bz, d, rdy}, 4'b0001);
    seen_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      samp(0);
      if (d !== 1'b0 || v !== 1'b0) seen_done = 1'b1;
    end
    chk("t5_no_done", seen_done, 1'b0);
    req(0, 4'b0110, 3'd3, 4'd2);
    capture(0, 20, 1'b0);
    chk("t5_new_bits", cap_bits, 32'h36);
    chk("t5_new_done_at", cap_done, 7);
    after_done(0, "t5");

    // abort beats in_valid in the same cycle
    drive(0, 1'b1, 4'b1011, 3'd4, 4'd1, 1'b1);
    @(negedge clk);
    drive(0, 1'b0, 4'h0, 3'd0, 4'd0, 1'b0);
    samp(0);
    chk("t5_abort_priority", {v, bz, rdy}, 3'b001);

    // reset mid-transfer
    req(0, 4'b1011, 3'd4, 4'd3);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    samp(0);
    chk("t5_reset_mid", {v, bz, d, rdy}, 4'b0001);
    @(negedge clk);
    samp(0);
    chk("t5_reset_idle", {v, bz, d, rdy}, 4'b0001);

    // loopback with request noise while busy
    req(0, 4'b1011, 3'd4, 4'd1);
    capture(0, 20, 1'b1);
    chk("t6_bits", cap_bits, 32'hB);
    chk("t6_seq_seen", cap_seen, 1);
    chk("t6_done_at", cap_done, 5);
    after_done(0, "t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
